// File: rtl/bkm_steps_pkg.sv
// Shared types and constants for the bkm_steps stimulus generator:
// FSM encoding, BKM digit codes and the 64-bit Galois LFSR step.
package bkm_steps_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_POS  = 2'b01;
    localparam logic [1:0] D_NEG  = 2'b11;

    // Taps 64,63,61,60 for a right-shifting Galois register
    localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0000_0000_0001;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'd0);
    endfunction

    // Raw code 2'b10 has no meaning as a BKM digit; fold it onto zero.
    function automatic logic [1:0] digit(input logic [1:0] code);
        return (code == 2'b10) ? D_ZERO : code;
    endfunction

endpackage

// File: rtl/bkm_lfsr64.sv
// 64-bit Galois LFSR with synchronous seed load and step enable.
module bkm_lfsr64
    import bkm_steps_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        srst,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [63:0] seed_i,
    output logic [63:0] state_o
);

    logic [63:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (advance_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= SEED;
        end else if (srst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bkm_steps_stimulus.sv
// Operand vector generator for the bkm_steps DUT with valid/ready pacing.
// Define BKM_STEPS_STIM_CORNERS_EN to prefix every run with three corner vectors.
module bkm_steps_stimulus
    import bkm_steps_pkg::*;
#(
    parameter int          WC      = 16,
    parameter int          WD      = 64,
    parameter int          LOG2N   = 6,
    parameter int          NUM_VEC = 1024,
    parameter logic [63:0] SEED    = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             cfg_mode,
    input  logic [1:0]       cfg_format,
    input  logic             cfg_sweep,
    input  logic [LOG2N-1:0] cfg_n,
    input  logic             ready,
    output logic             valid,
    output logic             tb_mode,
    output logic [1:0]       tb_format,
    output logic [LOG2N-1:0] tb_n,
    output logic [1:0]       tb_d_x_n,
    output logic [1:0]       tb_d_y_n,
    output logic [WC-1:0]    tb_u_n,
    output logic [WC-1:0]    tb_v_n,
    output logic [WD-1:0]    tb_X_n,
    output logic [WD-1:0]    tb_Y_n,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_cnt
);

    // Packed operand vector: {d_x, d_y, u, v, X, Y}
    localparam int          VW        = 4 + 2*WC + 2*WD;
    localparam logic [31:0] NUM_VEC_W = 32'(NUM_VEC);

    function automatic logic [VW-1:0] rand_vec(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = s[63-i];
        end
        return {digit(s[1:0]), digit(s[3:2]), s[WC-1:0] ^ s[63 -: WC],
                s[16 +: WC], s[WD-1:0], r[WD-1:0]};
    endfunction

    function automatic logic [VW-1:0] corner_vec(input logic [1:0] k);
        logic [VW-1:0] v;
        case (k)
            2'd1:    v = {D_NEG, D_NEG, {WC{1'b1}}, {WC{1'b1}}, {WD{1'b1}}, {WD{1'b1}}};
            2'd2:    v = {D_POS, D_POS, 1'b0, {(WC-1){1'b1}}, 1'b0, {(WC-1){1'b1}},
                          1'b0, {(WD-1){1'b1}}, 1'b0, {(WD-1){1'b1}}};
            default: v = '0;
        endcase
        return v;
    endfunction

    state_e            state_q, state_d;
    logic [VW-1:0]     vec_q, load_vec, run_vec;
    logic [31:0]       vec_cnt_q, cnt_inc;
    logic [LOG2N-1:0]  n_q;
    logic [1:0]        format_q;
    logic              mode_q, sweep_q, valid_q, done_q;
    logic              start_load, do_load, hs, last_hs, lfsr_adv;
    logic [63:0]       lfsr_q, lfsr_nxt;

    bkm_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk       (clk),
        .arst      (arst),
        .srst      (srst),
        .load_i    (start_load),
        .advance_i (lfsr_adv),
        .seed_i    (SEED),
        .state_o   (lfsr_q)
    );

    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign cnt_inc  = (vec_cnt_q == 32'hFFFF_FFFF) ? vec_cnt_q : vec_cnt_q + 32'd1;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        do_load    = 1'b0;
        hs         = 1'b0;
        last_hs    = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = LOAD;
                        start_load = 1'b1;
                    end
                end
                LOAD: begin
                    state_d = RUN;
                    do_load = 1'b1;
                end
                RUN: begin
                    if (valid_q && ready) begin
                        hs = 1'b1;
                        if (cnt_inc >= NUM_VEC_W) begin
                            last_hs = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The LFSR only moves when a random vector is replaced by the next random one.
    always_comb begin
        lfsr_adv = 1'b0;
`ifdef BKM_STEPS_STIM_CORNERS_EN
        load_vec = corner_vec(2'd0);
        if (cnt_inc < 32'd3) begin
            run_vec = corner_vec(cnt_inc[1:0]);
        end else if (cnt_inc == 32'd3) begin
            run_vec = rand_vec(lfsr_q);
        end else begin
            run_vec  = rand_vec(lfsr_nxt);
            lfsr_adv = hs && !last_hs;
        end
`else
        load_vec = rand_vec(lfsr_q);
        run_vec  = rand_vec(lfsr_nxt);
        lfsr_adv = hs && !last_hs;
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vec_q     <= '0;
            vec_cnt_q <= '0;
            n_q       <= '0;
            format_q  <= '0;
            mode_q    <= 1'b0;
            sweep_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else if (srst) begin
            vec_q     <= '0;
            vec_cnt_q <= '0;
            n_q       <= '0;
            format_q  <= '0;
            mode_q    <= 1'b0;
            sweep_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (start_load) begin
                vec_cnt_q <= '0;
                done_q    <= 1'b0;
            end
            if (do_load) begin
                mode_q   <= cfg_mode;
                format_q <= cfg_format;
                n_q      <= cfg_n;
                sweep_q  <= cfg_sweep;
                vec_q    <= load_vec;
                valid_q  <= 1'b1;
            end
            if (hs) begin
                vec_cnt_q <= cnt_inc;
                if (last_hs) begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    vec_q <= run_vec;
                    if (sweep_q) begin
                        n_q <= n_q + 1'b1;
                    end
                end
            end
        end
    end

    assign valid     = valid_q;
    assign done      = done_q;
    assign vec_cnt   = vec_cnt_q;
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign tb_mode   = mode_q;
    assign tb_format = format_q;
    assign tb_n      = n_q;
    assign tb_Y_n    = vec_q[WD-1:0];
    assign tb_X_n    = vec_q[2*WD-1:WD];
    assign tb_v_n    = vec_q[2*WD +: WC];
    assign tb_u_n    = vec_q[2*WD+WC +: WC];
    assign tb_d_y_n  = vec_q[2*WD+2*WC +: 2];
    assign tb_d_x_n  = vec_q[2*WD+2*WC+2 +: 2];

endmodule

// File: tb/tb_bkm_steps_stimulus.sv
// Scoreboard bench for bkm_steps_stimulus: an independent vector model fills
// a queue at run start, and every accepted vector is popped and compared.
module tb_bkm_steps_stimulus;

    localparam int          NV   = 6;
    localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

    logic        clk = 1'b0;
    logic        arst, srst, enable, start, cfg_mode, cfg_sweep, ready;
    logic [1:0]  cfg_format;
    logic [5:0]  cfg_n;
    logic        valid, tb_mode, busy, done;
    logic [1:0]  tb_format, tb_d_x_n, tb_d_y_n;
    logic [5:0]  tb_n;
    logic [15:0] tb_u_n, tb_v_n;
    logic [63:0] tb_X_n, tb_Y_n;
    logic [31:0] vec_cnt;

    typedef struct packed {
        logic [1:0]  dx, dy;
        logic [15:0] u, v;
        logic [63:0] x, y;
        logic [5:0]  n;
        logic        m;
        logic [1:0]  f;
    } vec_t;

    vec_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bkm_steps_stimulus #(.WC(16), .WD(64), .LOG2N(6), .NUM_VEC(NV), .SEED(SEED)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
        .cfg_mode(cfg_mode), .cfg_format(cfg_format), .cfg_sweep(cfg_sweep),
        .cfg_n(cfg_n), .ready(ready), .valid(valid), .tb_mode(tb_mode),
        .tb_format(tb_format), .tb_n(tb_n), .tb_d_x_n(tb_d_x_n),
        .tb_d_y_n(tb_d_y_n), .tb_u_n(tb_u_n), .tb_v_n(tb_v_n),
        .tb_X_n(tb_X_n), .tb_Y_n(tb_Y_n), .busy(busy), .done(done),
        .vec_cnt(vec_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [63:0] r;
        r = {1'b0, s[63:1]};
        if (s[0]) begin
            r[63] = ~r[63];
            r[62] = ~r[62];
            r[60] = ~r[60];
            r[59] = ~r[59];
        end
        return r;
    endfunction

    function automatic logic [1:0] m_dig(input logic [1:0] c);
        return (c == 2'b10) ? 2'b00 : c;
    endfunction

    function automatic vec_t m_rand(input logic [63:0] s);
        vec_t e;
        e = '0;
        for (int i = 0; i < 64; i++) e.y[i] = s[63-i];
        e.x  = s;
        e.u  = s[15:0] ^ s[63:48];
        e.v  = s[31:16];
        e.dx = m_dig(s[1:0]);
        e.dy = m_dig(s[3:2]);
        return e;
    endfunction

    function automatic vec_t m_corner(input int k);
        vec_t e;
        e = '0;
        if (k == 1) begin
            e.dx = 2'b11; e.dy = 2'b11;
            e.u = 16'hFFFF; e.v = 16'hFFFF;
            e.x = 64'hFFFF_FFFF_FFFF_FFFF; e.y = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (k == 2) begin
            e.dx = 2'b01; e.dy = 2'b01;
            e.u = 16'h7FFF; e.v = 16'h7FFF;
            e.x = 64'h7FFF_FFFF_FFFF_FFFF; e.y = 64'h7FFF_FFFF_FFFF_FFFF;
        end
        return e;
    endfunction

    task automatic push_run(input logic m, input logic [1:0] f, input logic sw, input logic [5:0] n0);
        logic [63:0] s;
        vec_t        e;
        s = SEED;
        for (int k = 0; k < NV; k++) begin
`ifdef BKM_STEPS_STIM_CORNERS_EN
            if (k < 3) begin
                e = m_corner(k);
            end else begin
                e = m_rand(s);
                s = m_step(s);
            end
`else
            e = m_rand(s);
            s = m_step(s);
`endif
            e.n = sw ? 6'(int'(n0) + k) : n0;
            e.m = m;
            e.f = f;
            sb.push_back(e);
        end
    endtask

    task automatic begin_run(input logic m, input logic [1:0] f, input logic sw, input logic [5:0] n0);
        cfg_mode = m; cfg_format = f; cfg_sweep = sw; cfg_n = n0;
        push_run(m, f, sw, n0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_load", busy, 1);
        chk("valid_load", valid, 0);
        tick();
    endtask

    // rpat 0: ready always high; rpat 1: ready pattern 1,0,0,1 repeating
    task automatic consume(input int rpat, input int stop_at);
        int   cyc, nhs;
        vec_t e;
        logic [63:0] hx;
        logic [31:0] hc;
        cyc = 0;
        nhs = 0;
        while (!done && cyc < 200 && nhs != stop_at) begin
            ready = (rpat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start = (cyc == 2);
            if (cyc == 2) cfg_n = cfg_n + 6'd5;
            if (valid && ready && enable) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk("vec_cnt", vec_cnt, NV - sb.size());
                    e = sb.pop_front();
                    chk("X", tb_X_n, e.x);
                    chk("Y", tb_Y_n, e.y);
                    chk("uv", {tb_u_n, tb_v_n}, {e.u, e.v});
                    chk("digits", {tb_d_x_n, tb_d_y_n}, {e.dx, e.dy});
                    chk("n", tb_n, e.n);
                    chk("mode_fmt", {tb_mode, tb_format}, {e.m, e.f});
                    chk("dig_legal", (tb_d_x_n == 2'b10) || (tb_d_y_n == 2'b10), 0);
                end
                nhs++;
                tick();
            end else begin
                hx = tb_X_n;
                hc = vec_cnt;
                tick();
                chk("stall_X", tb_X_n, hx);
                chk("stall_cnt", vec_cnt, hc);
            end
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) chk("timeout", 1, 0);
    endtask

    task automatic end_checks();
        chk("done_end", done, 1);
        chk("valid_end", valid, 0);
        chk("busy_end", busy, 0);
        chk("cnt_end", vec_cnt, NV);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        logic [63:0] hx, hy;
        logic [31:0] hc;
        logic [5:0]  hn;
        arst = 1'b1; srst = 1'b0; enable = 1'b1; start = 1'b0; ready = 1'b0;
        cfg_mode = 1'b0; cfg_format = 2'd0; cfg_sweep = 1'b0; cfg_n = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", vec_cnt, 0);
        chk("rst_X", tb_X_n, 0);
        arst = 1'b0;
        tick();

        // sweep wraps 62,63,0,1,...
        begin_run(1'b1, 2'd2, 1'b1, 6'd62);
        consume(0, -1);
        end_checks();

        // second start must reproduce the same stream
        begin_run(1'b1, 2'd2, 1'b1, 6'd62);
        consume(0, -1);
        end_checks();

        // ready stalls, fixed n
        begin_run(1'b0, 2'd1, 1'b0, 6'd17);
        consume(1, -1);
        end_checks();

        // enable low in RUN freezes everything
        begin_run(1'b1, 2'd3, 1'b1, 6'd5);
        consume(0, 2);
        ready = 1'b1;
        enable = 1'b0;
        hx = tb_X_n; hy = tb_Y_n; hc = vec_cnt; hn = tb_n;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en0_XY", tb_X_n ^ tb_Y_n, hx ^ hy);
            chk("en0_cnt_n", {hn, vec_cnt}, {tb_n, hc});
        end
        chk("en0_valid", valid, 1);
        enable = 1'b1;
        consume(0, -1);
        end_checks();

        // async reset mid-run
        begin_run(1'b0, 2'd0, 1'b1, 6'd0);
        consume(0, 5);
        chk("pre_arst_cnt", vec_cnt, 5);
        #2 arst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_cnt", vec_cnt, 0);
        #2 arst = 1'b0;
        tick();
        chk("post_arst_busy", busy, 0);
        chk("post_arst_X", tb_X_n, 0);
        chk("post_arst_valid", valid, 0);
        sb.delete();

        // full run, then sync reset beats a simultaneous start
        begin_run(1'b0, 2'd1, 1'b0, 6'd9);
        consume(0, -1);
        end_checks();
        srst = 1'b1;
        start = 1'b1;
        tick();
        srst = 1'b0;
        start = 1'b0;
        chk("srst_done", done, 0);
        chk("srst_cnt", vec_cnt, 0);
        chk("srst_X", tb_X_n, 0);
        chk("srst_busy", busy, 0);
        tick();
        chk("srst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
